// File: rtl/wdt_esc_ctrl_if.sv
// Signal bundle between the watchdog escalation controller and its environment.
// slave = controller side, master = requesters / watchdog / reset-controller side.
interface wdt_esc_ctrl_if #(
    parameter int NUM_REQ = 4,
    parameter int ESC_W   = 16
);
    logic [NUM_REQ-1:0] req_en_i;
    logic [NUM_REQ-1:0] kick_i;
    logic               wdt_ovf_i;
    logic               wdt_clear_o;
    logic [ESC_W-1:0]   esc_timeout_i;
    logic               esc_ack_i;
    logic               irq_o;
    logic               nmi_o;
    // Reset handshake: rst_req_o acts as valid and stays high until rst_ack_i
    // (ready) is sampled high in the same cycle; the transfer completes on that edge.
    logic               rst_req_o;
    logic               rst_ack_i;
    logic [NUM_REQ-1:0] kicked_o;
    logic [1:0]         state_o;

    modport slave (
        input  req_en_i, kick_i, wdt_ovf_i, esc_timeout_i, esc_ack_i, rst_ack_i,
        output wdt_clear_o, irq_o, nmi_o, rst_req_o, kicked_o, state_o
    );

    modport master (
        output req_en_i, kick_i, wdt_ovf_i, esc_timeout_i, esc_ack_i, rst_ack_i,
        input  wdt_clear_o, irq_o, nmi_o, rst_req_o, kicked_o, state_o
    );
endinterface

// File: rtl/wdt_esc_ctrl.sv
// Watchdog kick aggregator and staged escalation sequencer (IRQ -> NMI -> reset request).
// Define WDT_ESC_NMI_EN to include the NMI stage; otherwise IRQ escalates straight to reset.
module wdt_esc_ctrl #(
    parameter int NUM_REQ = 4,
    parameter int ESC_W   = 16
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    wdt_esc_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_IRQ  = 2'd1,
        ST_NMI  = 2'd2,
        ST_RST  = 2'd3
    } state_e;

`ifdef WDT_ESC_NMI_EN
    localparam state_e IRQ_NEXT = ST_NMI;
`else
    localparam state_e IRQ_NEXT = ST_RST;
`endif

    state_e             state_q, state_d;
    logic [ESC_W-1:0]   timer_q, timer_d;
    logic [NUM_REQ-1:0] kicked_q, kicked_d;
    logic               clear_q, clear_d;

    logic [NUM_REQ-1:0] next_kicked;
    logic               round_done;
    logic               expired;

    assign next_kicked = kicked_q | (bus.kick_i & bus.req_en_i);
    assign round_done  = (&(next_kicked | ~bus.req_en_i)) && (|bus.req_en_i);
    assign expired     = (timer_q == '0);

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        kicked_d = '0;
        clear_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // Overflow wins over a completing kick: escalate without restarting.
                if (bus.wdt_ovf_i) begin
                    state_d = ST_IRQ;
                    timer_d = bus.esc_timeout_i;
                end else if (round_done) begin
                    clear_d = 1'b1;
                end else begin
                    kicked_d = next_kicked;
                end
            end
            ST_IRQ, ST_NMI: begin
                if (bus.esc_ack_i) begin
                    state_d = ST_IDLE;
                    clear_d = 1'b1;
                end else if (expired || bus.wdt_ovf_i) begin
                    state_d = (state_q == ST_IRQ) ? IRQ_NEXT : ST_RST;
                    timer_d = bus.esc_timeout_i;
                end else begin
                    timer_d = timer_q - ESC_W'(1);
                end
            end
            ST_RST: begin
                if (bus.rst_ack_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            timer_q  <= '0;
            kicked_q <= '0;
            clear_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            kicked_q <= kicked_d;
            clear_q  <= clear_d;
        end
    end

    // Stage outputs decode the registered state, so they are glitch-free and one-hot.
    assign bus.state_o     = state_q;
    assign bus.kicked_o    = kicked_q;
    assign bus.wdt_clear_o = clear_q;
    assign bus.irq_o       = (state_q == ST_IRQ);
    assign bus.rst_req_o   = (state_q == ST_RST);
`ifdef WDT_ESC_NMI_EN
    assign bus.nmi_o       = (state_q == ST_NMI);
`else
    assign bus.nmi_o       = 1'b0;
`endif

endmodule

// File: tb/tb_wdt_esc_ctrl.sv
// Directed bench for wdt_esc_ctrl: kick rounds, escalation timing, precedence and reset.
module tb_wdt_esc_ctrl;

  localparam int NUM_REQ = 4;
  localparam int ESC_W   = 16;
`ifdef WDT_ESC_NMI_EN
  localparam int ST_AFTER_IRQ = 2;
`else
  localparam int ST_AFTER_IRQ = 3;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  wdt_esc_ctrl_if #(.NUM_REQ(NUM_REQ), .ESC_W(ESC_W)) bus ();

  wdt_esc_ctrl #(.NUM_REQ(NUM_REQ), .ESC_W(ESC_W)) u_dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input int st, input logic clr, input logic [3:0] kk);
    check({tag, ".state"},  32'(bus.state_o), 32'(st));
    check({tag, ".irq"},    32'(bus.irq_o),   32'(st == 1));
    check({tag, ".nmi"},    32'(bus.nmi_o),   32'(st == 2));
    check({tag, ".rstreq"}, 32'(bus.rst_req_o), 32'(st == 3));
    check({tag, ".clear"},  32'(bus.wdt_clear_o), 32'(clr));
    check({tag, ".kicked"}, 32'(bus.kicked_o), 32'(kk));
  endtask

  // Advance one clock; outputs settle #1 after the edge, single-cycle pulses drop.
  task automatic step();
    @(posedge clk);
    #1;
    bus.kick_i    = '0;
    bus.wdt_ovf_i = 1'b0;
    bus.esc_ack_i = 1'b0;
    bus.rst_ack_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    check_out("reset", 0, 1'b0, 4'b0000);
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    rst_n             = 1'b0;
    bus.req_en_i      = '0;
    bus.kick_i        = '0;
    bus.wdt_ovf_i     = 1'b0;
    bus.esc_timeout_i = '0;
    bus.esc_ack_i     = 1'b0;
    bus.rst_ack_i     = 1'b0;
    do_reset();

    // Kick round with requester 2 disabled.
    bus.req_en_i = 4'b1011;
    bus.kick_i = 4'b0001; step(); check_out("k0", 0, 1'b0, 4'b0001);
    bus.kick_i = 4'b0100; step(); check_out("k2_dis", 0, 1'b0, 4'b0001);
    bus.kick_i = 4'b0001; step(); check_out("k0_again", 0, 1'b0, 4'b0001);
    bus.kick_i = 4'b0010; step(); check_out("k1", 0, 1'b0, 4'b0011);
    bus.esc_ack_i = 1'b1; bus.rst_ack_i = 1'b1;
    step(); check_out("ack_idle_ign", 0, 1'b0, 4'b0011);
    bus.kick_i = 4'b1000; step(); check_out("k3_done", 0, 1'b1, 4'b0000);
    step(); check_out("clr_one_cyc", 0, 1'b0, 4'b0000);

    // Several kicks in one cycle complete a round at once.
    bus.kick_i = 4'b1111; step(); check_out("kall", 0, 1'b1, 4'b0000);
    step();

    // No participating requesters: never clears.
    bus.req_en_i = 4'b0000;
    bus.kick_i = 4'b1111; step(); check_out("en0", 0, 1'b0, 4'b0000);
    step(); check_out("en0_b", 0, 1'b0, 4'b0000);

    // Full escalation, timeout 3, no ack.
    bus.req_en_i = 4'b1011;
    bus.esc_timeout_i = 16'd3;
    bus.wdt_ovf_i = 1'b1; step();
    for (int i = 0; i < 4; i++) begin
      if (i == 1) bus.kick_i = 4'b1011;
      check_out($sformatf("irq%0d", i), 1, 1'b0, 4'b0000);
      step();
    end
`ifdef WDT_ESC_NMI_EN
    for (int i = 0; i < 4; i++) begin
      check_out($sformatf("nmi%0d", i), 2, 1'b0, 4'b0000);
      step();
    end
`endif
    for (int i = 0; i < 3; i++) begin
      check_out($sformatf("rst%0d", i), 3, 1'b0, 4'b0000);
      bus.esc_ack_i = 1'b1;
      step();
    end
    check_out("rst_held", 3, 1'b0, 4'b0000);
    bus.rst_ack_i = 1'b1; step();
    check_out("rst_acked", 0, 1'b0, 4'b0000);

    // Ack coincides with timer expiry in IRQ.
    bus.esc_timeout_i = 16'd1;
    bus.wdt_ovf_i = 1'b1; step(); check_out("ae_irq0", 1, 1'b0, 4'b0000);
    step(); check_out("ae_irq1", 1, 1'b0, 4'b0000);
    bus.esc_ack_i = 1'b1; step(); check_out("ae_idle", 0, 1'b1, 4'b0000);
    step(); check_out("ae_after", 0, 1'b0, 4'b0000);

    // Final kick and overflow together: escalate, no clear.
    bus.kick_i = 4'b0011; step(); check_out("pk_pre", 0, 1'b0, 4'b0011);
    bus.kick_i = 4'b1000; bus.wdt_ovf_i = 1'b1;
    step(); check_out("pk_ovf", 1, 1'b0, 4'b0000);
    step(); check_out("pk_ovf_b", 1, 1'b0, 4'b0000);

    // Further overflow in IRQ advances immediately.
    bus.wdt_ovf_i = 1'b1; step(); check_out("ovf_adv", ST_AFTER_IRQ, 1'b0, 4'b0000);
    if (ST_AFTER_IRQ == 2) begin
      bus.esc_ack_i = 1'b1; step(); check_out("nmi_ack", 0, 1'b1, 4'b0000);
    end else begin
      bus.rst_ack_i = 1'b1; step(); check_out("rst_ack2", 0, 1'b0, 4'b0000);
    end
    step();

    // Zero timeout: single-cycle dwell per stage.
    bus.esc_timeout_i = 16'd0;
    bus.wdt_ovf_i = 1'b1; step(); check_out("t0_irq", 1, 1'b0, 4'b0000);
    step(); check_out("t0_next", ST_AFTER_IRQ, 1'b0, 4'b0000);

    // Asynchronous reset mid-escalation.
    rst_n = 1'b0;
    #2;
    check_out("async_rst", 0, 1'b0, 4'b0000);
    step();
    rst_n = 1'b1;
    step(); check_out("post_rst", 0, 1'b0, 4'b0000);
    bus.kick_i = 4'b0001; step(); check_out("post_rst_k", 0, 1'b0, 4'b0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wdt_esc_ctrl.md
# wdt_esc_ctrl

Watchdog service and escalation controller placed between the cluster requesters and the watchdog counter. Aggregates kick pulses from up to NUM_REQ independent requesters into a single counter-restart pulse, and sequences a staged escalation (interrupt, NMI, system reset request) when the watchdog reports overflow. It is the only block allowed to drive the watchdog clear. It owns the reset-request handshake with the SoC reset controller.

## Interface
- NUM_REQ, 4, number of kick requesters (1..32)
- ESC_W, 16, width of escalation timeout in cycles
- clk_i  in  1  clock; all logic in this single domain
- rst_ni  in  1  asynchronous active-low reset
- req_en_i  in  NUM_REQ  participating-requester mask (quasi-static)
- kick_i  in  NUM_REQ  single-cycle kick pulse per requester
- wdt_ovf_i  in  1  single-cycle overflow pulse from watchdog
- wdt_clear_o  out  1  single-cycle restart pulse to watchdog
- esc_timeout_i  in  ESC_W  cycles spent in each escalation stage
- esc_ack_i  in  1  software acknowledge, valid in IRQ/NMI stages
- irq_o  out  1  level, high in IRQ stage
- nmi_o  out  1  level, high in NMI stage
- rst_req_o  out  1  reset request, held until acknowledged
- rst_ack_i  in  1  reset controller acknowledge
- kicked_o  out  NUM_REQ  current-round kick mask
- state_o  out  2  0=IDLE 1=IRQ 2=NMI 3=RST

## Operation
- All outputs registered; reset value of every output 0, state IDLE, kicked mask 0, timer 0.
- Kick round (IDLE only): kicked[i] set on kick_i[i] & req_en_i[i]; kicks from disabled requesters ignored. A kick arriving on a cycle that completes the round counts for that round.
- Round complete when next_kicked | ~req_en_i is all-ones and req_en_i != 0: wdt_clear_o pulses next cycle, kicked cleared. req_en_i == 0: never clears.
- Kicks in IRQ/NMI/RST ignored, kicked mask held at 0.
- FSM: IDLE -> IRQ on wdt_ovf_i. IRQ -> NMI on timer expiry or further wdt_ovf_i. NMI -> RST on timer expiry or wdt_ovf_i. RST -> IDLE on rst_ack_i.
- Timer loaded with esc_timeout_i on each stage entry, decrements each cycle, expiry when 0; esc_timeout_i == 0 gives expiry on first cycle in stage (one cycle dwell).
- esc_ack_i in IRQ or NMI: -> IDLE, wdt_clear_o pulse, kicked cleared. esc_ack_i ignored in IDLE and RST.
- Precedence: wdt_ovf_i over round completion in IDLE (enter IRQ, no clear, kicked cleared); esc_ack_i over timer expiry and wdt_ovf_i in IRQ/NMI.
- rst_req_o high throughout RST; rst_ack_i outside RST ignored.
- Reset mid-escalation returns everything to reset values; no pending pulse survives.

## Timing
- kick_i at cycle N completing round -> wdt_clear_o high at N+1 only.
- wdt_ovf_i at N -> state_o=1, irq_o high at N+1.
- Stage dwell = esc_timeout_i + 1 cycles absent events.
- esc_ack_i at N -> state_o=0, outputs low, wdt_clear_o high at N+1.
- rst_ack_i at N in RST -> rst_req_o low, state_o=0 at N+1.
- Outputs one-hot across irq_o/nmi_o/rst_req_o.

## Configuration
- WDT_ESC_NMI_EN defined: NMI stage present as above.
- Undefined: IRQ -> RST directly on timer expiry or wdt_ovf_i; nmi_o tied 0; state_o never 2.

## Test plan
- req_en_i=4'b1011, kicks on 0,1 then 3 at cycle 10 -> wdt_clear_o high cycle 11 only, kicked_o=0 at 11; kick on 2 ignored.
- wdt_ovf_i at cycle 5, esc_timeout_i=3, no ack -> IRQ 6..9, NMI 10..13, rst_req_o from 14 until rst_ack_i, IDLE cycle after ack.
- IRQ stage, esc_ack_i same cycle as timer expiry -> IDLE next cycle, wdt_clear_o pulse, no NMI.
- IDLE, final kick and wdt_ovf_i same cycle -> IRQ, wdt_clear_o stays 0, kicked_o=0.
- rst_ni low during NMI -> all outputs 0 immediately, IDLE on release; without WDT_ESC_NMI_EN, IRQ expiry goes to state 3.
